// File: rtl/parity_check_arbiter.sv
// parity_check_arbiter
// Shares one even-parity checker between two requesters with round-robin
// arbitration. A granted word is latched, checked one cycle later, and the
// result is returned as a one-cycle done/err pulse to the granted requester.
// Optional feature macro: PARITY_ERR_CNT_EN builds the saturating parity
// error counter; without it err_cnt is tied to zero.
module parity_check_arbiter #(
   parameter int W     = 9,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [W-1:0]     word0,
   input  logic [W-1:0]     word1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic             err,
   output logic             busy,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t         state;
   logic [W-1:0]   word_q;
   logic           sel;     // requester currently being served
   logic           prio;    // requester that wins a tie
   logic           err_q;
   logic           win;

   // Winner of the IDLE sample: a lone request wins outright, a tie goes to prio
   always_comb begin
      win = 1'b0;
      if (req0 && req1)
         win = prio;
      else if (req1)
         win = 1'b1;
   end

   assign err = err_q;

   // Control FSM with registered grant/done/err/busy outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         word_q <= '0;
         sel    <= 1'b0;
         prio   <= 1'b0;
         err_q  <= 1'b0;
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         done0  <= 1'b0;
         done1  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  sel    <= win;
                  word_q <= win ? word1 : word0;
                  gnt0   <= ~win;
                  gnt1   <= win;
                  busy   <= 1'b1;
                  state  <= CHECK;
               end
            end
            CHECK: begin
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
               err_q <= ^word_q;
               done0 <= ~sel;
               done1 <= sel;
               state <= RESP;
            end
            RESP: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               err_q <= 1'b0;
               busy  <= 1'b0;
               prio  <= ~sel;
               state <= IDLE;
            end
            default: begin
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
               done0 <= 1'b0;
               done1 <= 1'b0;
               err_q <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef PARITY_ERR_CNT_EN
   logic [CNT_W-1:0] cnt;

   // Saturating error count, bumped on the edge that leaves RESP
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (state == RESP && err_q && cnt != '1)
         cnt <= cnt + CNT_W'(1);
   end

   assign err_cnt = cnt;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Self-checking bench for parity_check_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level model.
module tb_parity_check_arbiter;

   localparam int W       = 9;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0, req1;
   logic [W-1:0]     word0, word1;
   logic             gnt0, gnt1, done0, done1, err, busy;
   logic [CNT_W-1:0] err_cnt;

   int checks = 0;
   int errors = 0;

   // transaction-level model state
   bit m_prio;
   int m_cnt;

   always #5 clk = ~clk;

   parity_check_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .word0(word0), .word1(word1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .err(err), .busy(busy), .err_cnt(err_cnt)
   );

   function automatic bit parity_of(input logic [W-1:0] w);
      return ($countones(w) % 2) == 1;
   endfunction

   function automatic bit pick(input bit r0, input bit r1, input bit p);
      if (r0 && r1) return p;
      return r1;
   endfunction

   function automatic int bump(input int c, input bit e);
`ifdef PARITY_ERR_CNT_EN
      return (c + int'(e) > CNT_MAX) ? CNT_MAX : c + int'(e);
`else
      return 0;
`endif
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; word0 = '0; word1 = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({gnt0, gnt1, done0, done1, err, busy} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 000000", {gnt0, gnt1, done0, done1, err, busy});
      end
      checks++;
      if (err_cnt !== '0) begin
         errors++;
         $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
      end
      rst_n = 1'b1;
      m_prio = 1'b0;
      m_cnt = 0;
   endtask

   task automatic test_single_odd;
      bit e;
      word0 = 9'b000000100; req0 = 1'b1;
      e = parity_of(word0);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, busy, done0} !== 4'b1010) begin
         errors++;
         $display("FAIL odd_grant: got gnt0,gnt1,busy,done0=%b expected 1010", {gnt0, gnt1, busy, done0});
      end
      @(negedge clk);
      checks++;
      if ({done0, done1, err, gnt0} !== {1'b1, 1'b0, e, 1'b0}) begin
         errors++;
         $display("FAIL odd_done: got done0,done1,err,gnt0=%b expected %b", {done0, done1, err, gnt0}, {1'b1, 1'b0, e, 1'b0});
      end
      req0 = 1'b0;
      m_prio = 1'b1;
      m_cnt = bump(m_cnt, e);
      @(negedge clk);
      checks++;
      if ({busy, done0, err} !== 3'b000 || err_cnt !== CNT_W'(m_cnt)) begin
         errors++;
         $display("FAIL odd_after: got busy,done0,err=%b cnt=%0d expected 000 cnt=%0d", {busy, done0, err}, err_cnt, m_cnt);
      end
   endtask

   task automatic test_even_words;
      logic [W-1:0] ws [2];
      ws[0] = 9'b000101011;
      ws[1] = 9'b000000000;
      for (int unsigned i = 0; i < 2; i++) begin
         word1 = ws[i]; req1 = 1'b1;
         @(negedge clk);
         checks++;
         if ({gnt0, gnt1, busy} !== 3'b011) begin
            errors++;
            $display("FAIL even_grant%0d: got gnt0,gnt1,busy=%b expected 011", i, {gnt0, gnt1, busy});
         end
         @(negedge clk);
         checks++;
         if ({done0, done1, err} !== {1'b0, 1'b1, parity_of(ws[i])}) begin
            errors++;
            $display("FAIL even_done%0d: got done0,done1,err=%b expected %b", i, {done0, done1, err}, {1'b0, 1'b1, parity_of(ws[i])});
         end
         req1 = 1'b0;
         m_prio = 1'b0;
         m_cnt = bump(m_cnt, parity_of(ws[i]));
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || err_cnt !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL even_after%0d: got busy=%b cnt=%0d expected 0 cnt=%0d", i, busy, err_cnt, m_cnt);
         end
      end
   endtask

   task automatic test_contention;
      bit w, e;
      word0 = 9'b101010101; word1 = 9'b110010100;
      req0 = 1'b1; req1 = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         w = pick(1'b1, 1'b1, m_prio);
         e = parity_of(w ? word1 : word0);
         @(negedge clk);
         checks++;
         if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL rr_grant%0d: got gnt1,gnt0=%b expected %b", i, {gnt1, gnt0}, (w ? 2'b10 : 2'b01));
         end
         @(negedge clk);
         checks++;
         if ({done1, done0, err} !== {w, ~w, e}) begin
            errors++;
            $display("FAIL rr_done%0d: got done1,done0,err=%b expected %b", i, {done1, done0, err}, {w, ~w, e});
         end
         m_prio = ~w;
         m_cnt = bump(m_cnt, e);
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || err_cnt !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL rr_after%0d: got busy=%b cnt=%0d expected 0 cnt=%0d", i, busy, err_cnt, m_cnt);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_reset_mid;
      // serve requester 0 so that the tie pointer favours requester 1
      word0 = '0; req0 = 1'b1;
      repeat (2) @(negedge clk);
      req0 = 1'b0;
      m_prio = 1'b1;
      @(negedge clk);
      word1 = 9'b000000001; req1 = 1'b1;
      @(negedge clk);
      checks++;
      if (gnt1 !== 1'b1) begin
         errors++;
         $display("FAIL mid_grant: got gnt1=%b expected 1", gnt1);
      end
      rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, done0, done1, err, busy} !== 6'b0 || err_cnt !== '0) begin
         errors++;
         $display("FAIL mid_reset: got %b cnt=%0d expected 000000 cnt=0", {gnt0, gnt1, done0, done1, err, busy}, err_cnt);
      end
      rst_n = 1'b1;
      m_prio = 1'b0;
      m_cnt = 0;
      @(negedge clk);
      checks++;
      if ({gnt1, gnt0} !== 2'b01) begin
         errors++;
         $display("FAIL mid_first_grant: got gnt1,gnt0=%b expected 01", {gnt1, gnt0});
      end
      @(negedge clk);
      checks++;
      if ({done1, done0, err} !== {2'b01, parity_of(word0)}) begin
         errors++;
         $display("FAIL mid_done: got done1,done0,err=%b expected %b", {done1, done0, err}, {2'b01, parity_of(word0)});
      end
      req0 = 1'b0;
      m_prio = 1'b1;
      m_cnt = bump(m_cnt, parity_of(word0));
      @(negedge clk);
      req1 = 1'b0;
   endtask

   task automatic test_saturation;
      word0 = 9'b100000000;
      for (int unsigned i = 0; i < 5; i++) begin
         req0 = 1'b1;
         repeat (2) @(negedge clk);
         req0 = 1'b0;
         m_prio = 1'b1;
         m_cnt = bump(m_cnt, parity_of(word0));
         @(negedge clk);
         checks++;
         if (err_cnt !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL sat_cnt%0d: got %0d expected %0d", i, err_cnt, m_cnt);
         end
      end
   endtask

   task automatic test_random;
      bit r0, r1, w, e;
      r0 = 1'b0; r1 = 1'b0;
      for (int unsigned i = 0; i < 60; i++) begin
         if (!r0 && $urandom_range(1, 0) == 1) begin r0 = 1'b1; word0 = W'($urandom); end
         if (!r1 && $urandom_range(1, 0) == 1) begin r1 = 1'b1; word1 = W'($urandom); end
         req0 = r0; req1 = r1;
         if (!r0 && !r1) begin
            @(negedge clk);
            checks++;
            if ({busy, gnt0, gnt1} !== 3'b000) begin
               errors++;
               $display("FAIL rnd_idle%0d: got busy,gnt0,gnt1=%b expected 000", i, {busy, gnt0, gnt1});
            end
            continue;
         end
         w = pick(r0, r1, m_prio);
         e = parity_of(w ? word1 : word0);
         @(negedge clk);
         checks++;
         if ({gnt1, gnt0, busy} !== {w, ~w, 1'b1}) begin
            errors++;
            $display("FAIL rnd_grant%0d: got gnt1,gnt0,busy=%b expected %b", i, {gnt1, gnt0, busy}, {w, ~w, 1'b1});
         end
         // a loser request may appear while the checker is busy
         if (w && !r0 && $urandom_range(1, 0) == 1) begin r0 = 1'b1; word0 = W'($urandom); end
         if (!w && !r1 && $urandom_range(1, 0) == 1) begin r1 = 1'b1; word1 = W'($urandom); end
         if ($urandom_range(1, 0) == 1) begin
            if (w) r1 = 1'b0; else r0 = 1'b0;
         end
         req0 = r0; req1 = r1;
         @(negedge clk);
         checks++;
         if ({done1, done0, err} !== {w, ~w, e}) begin
            errors++;
            $display("FAIL rnd_done%0d: got done1,done0,err=%b expected %b", i, {done1, done0, err}, {w, ~w, e});
         end
         if (w) r1 = 1'b0; else r0 = 1'b0;
         req0 = r0; req1 = r1;
         m_prio = ~w;
         m_cnt = bump(m_cnt, e);
         @(negedge clk);
         checks++;
         if ({busy, done0, done1, err} !== 4'b0000 || err_cnt !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL rnd_after%0d: got busy,done0,done1,err=%b cnt=%0d expected 0000 cnt=%0d", i, {busy, done0, done1, err}, err_cnt, m_cnt);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_single_odd;
      test_even_words;
      test_contention;
      test_reset_mid;
      test_reset;
      test_saturation;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
